// File: rtl/fetch_pc_queue.sv
// Fetch PC generator + Icache request tracker + fetch queue; responses reach out_* one cycle later, or in the same cycle with FETCH_BYPASS_EN.
// Requests stall when queue space plus outstanding would exceed QDEPTH; the head holds steady while out_ready is low.
module fetch_pc_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] START_PC   = ADDR_WIDTH'(32'h8000_0000),
  parameter int                    QDEPTH     = 4,
  parameter int                    MAX_OUTST  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_excp_flag,
  input  logic [ADDR_WIDTH-1:0] ctrl_excp_pc,
  input  logic                  ex_branch_flag,
  input  logic [ADDR_WIDTH-1:0] ex_branch_pc,
  input  logic                  bp_branch_flag,
  input  logic [ADDR_WIDTH-1:0] bp_branch_pc,
  output logic                  ic_req_valid,
  input  logic                  ic_req_ready,
  output logic [ADDR_WIDTH-1:0] ic_req_addr,
  input  logic                  ic_resp_valid,
  input  logic [31:0]           ic_resp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [31:0]           out_instr
);

  localparam int QW = $clog2(QDEPTH);
  localparam int CW = QW + 1;
  localparam int AW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);

  logic [ADDR_WIDTH-1:0] r_next_pc;
  logic [OW-1:0]         r_outst;
  logic [OW-1:0]         r_stale;

  logic [ADDR_WIDTH-1:0] r_q_pc    [QDEPTH];
  logic [31:0]           r_q_instr [QDEPTH];
  logic [QW-1:0]         r_q_wptr;
  logic [QW-1:0]         r_q_rptr;
  logic [CW-1:0]         r_q_cnt;

  logic [ADDR_WIDTH-1:0] r_af      [MAX_OUTST];
  logic [AW-1:0]         r_af_wptr;
  logic [AW-1:0]         r_af_rptr;

  logic                  w_redir;
  logic [ADDR_WIDTH-1:0] w_redir_pc;
  logic                  w_room;
  logic                  w_req_acc;
  logic                  w_keep;
  logic                  w_byp;
  logic                  w_q_empty;
  logic                  w_push;
  logic                  w_pop;

  function automatic logic [AW-1:0] af_inc(input logic [AW-1:0] p);
    return (32'(p) == MAX_OUTST - 1) ? '0 : p + AW'(1);
  endfunction

  assign w_redir = ctrl_excp_flag | ex_branch_flag | bp_branch_flag;

  always_comb begin
    w_redir_pc = bp_branch_pc;
    if (ex_branch_flag) w_redir_pc = ex_branch_pc;
    if (ctrl_excp_flag) w_redir_pc = ctrl_excp_pc;
  end

  // Every outstanding request holds a queue slot, so a response can always be pushed.
  assign w_room       = (32'(r_q_cnt) + 32'(r_outst) < QDEPTH) && (32'(r_outst) < MAX_OUTST);
  assign ic_req_valid = !rst && !w_redir && w_room;
  assign ic_req_addr  = r_next_pc;
  assign w_req_acc    = ic_req_valid && ic_req_ready;

  assign w_keep    = ic_resp_valid && !rst && !w_redir && (r_stale == '0);
  assign w_q_empty = (r_q_cnt == '0);

`ifdef FETCH_BYPASS_EN
  assign w_byp = w_keep && w_q_empty;
`else
  assign w_byp = 1'b0;
`endif

  assign out_valid = !rst && (!w_q_empty || w_byp);
  assign out_pc    = !w_q_empty ? r_q_pc[r_q_rptr]    : (w_byp ? r_af[r_af_rptr] : '0);
  assign out_instr = !w_q_empty ? r_q_instr[r_q_rptr] : (w_byp ? ic_resp_data   : '0);

  assign w_pop  = out_valid && out_ready && !w_q_empty;
  assign w_push = w_keep && !(w_byp && out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_next_pc <= START_PC;
      r_outst   <= '0;
      r_stale   <= '0;
      r_q_wptr  <= '0;
      r_q_rptr  <= '0;
      r_q_cnt   <= '0;
      r_af_wptr <= '0;
      r_af_rptr <= '0;
    end else begin
      case ({w_req_acc, ic_resp_valid})
        2'b10:   r_outst <= r_outst + OW'(1);
        2'b01:   r_outst <= r_outst - OW'(1);
        default: r_outst <= r_outst;
      endcase
      if (w_req_acc)     r_af_wptr <= af_inc(r_af_wptr);
      if (ic_resp_valid) r_af_rptr <= af_inc(r_af_rptr);

      if (w_redir) begin
        r_next_pc <= w_redir_pc;
        // Whatever is still in flight after this cycle belongs to the old path.
        r_stale   <= r_outst - OW'(ic_resp_valid);
        r_q_wptr  <= '0;
        r_q_rptr  <= '0;
        r_q_cnt   <= '0;
      end else begin
        if (w_req_acc) r_next_pc <= r_next_pc + ADDR_WIDTH'(4);
        if (ic_resp_valid && (r_stale != '0)) r_stale <= r_stale - OW'(1);
        if (w_push) r_q_wptr <= r_q_wptr + QW'(1);
        if (w_pop)  r_q_rptr <= r_q_rptr + QW'(1);
        r_q_cnt <= r_q_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_acc) r_af[r_af_wptr] <= r_next_pc;
    if (w_push) begin
      r_q_pc[r_q_wptr]    <= r_af[r_af_rptr];
      r_q_instr[r_q_wptr] <= ic_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Randomized bench for fetch_pc_queue: Icache responder plus a queue-based reference of the fetch path.
module tb_fetch_pc_queue;

  localparam logic [31:0] START = 32'h8000_0000;
  localparam int QD = 4;
  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_excp_flag, ex_branch_flag, bp_branch_flag;
  logic [31:0] ctrl_excp_pc, ex_branch_pc, bp_branch_pc;
  logic        ic_req_valid, ic_req_ready;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;

  always #5 clk = ~clk;

  fetch_pc_queue #(
    .ADDR_WIDTH(32),
    .START_PC  (START),
    .QDEPTH    (QD),
    .MAX_OUTST (MO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl_excp_flag(ctrl_excp_flag),
    .ctrl_excp_pc  (ctrl_excp_pc),
    .ex_branch_flag(ex_branch_flag),
    .ex_branch_pc  (ex_branch_pc),
    .bp_branch_flag(bp_branch_flag),
    .bp_branch_pc  (bp_branch_pc),
    .ic_req_valid  (ic_req_valid),
    .ic_req_ready  (ic_req_ready),
    .ic_req_addr   (ic_req_addr),
    .ic_resp_valid (ic_resp_valid),
    .ic_resp_data  (ic_resp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } ic_ent_t;
  typedef struct { logic [31:0] addr; bit stale; } fl_ent_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } q_ent_t;

  ic_ent_t     icq[$];
  fl_ent_t     mo[$];
  q_ent_t      mq[$];
  logic [31:0] m_pc;
  int          n_cmp, n_bad, cyc, n_acc, lat_lo, lat_hi;
  bit          last_ov;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: entered and left at a falling edge.
  task automatic step(input bit r, input bit ex, input logic [31:0] expc,
                      input bit br, input logic [31:0] brpc,
                      input bit bp, input logic [31:0] bppc,
                      input bit rdy, input bit ordy);
    bit          resp, redir, keep, byp, exp_rv, exp_ov, hs;
    logic [31:0] tgt, rdata;
    fl_ent_t     e;
    int          lat;
    if (r) icq.delete();
    resp  = !r && icq.size() > 0 && icq[0].due <= cyc;
    rdata = resp ? icq[0].data : 32'h0;
    rst            = r;
    ctrl_excp_flag = ex;  ctrl_excp_pc = expc;
    ex_branch_flag = br;  ex_branch_pc = brpc;
    bp_branch_flag = bp;  bp_branch_pc = bppc;
    ic_req_ready   = rdy;
    ic_resp_valid  = resp;
    ic_resp_data   = resp ? rdata : $urandom;
    out_ready      = ordy;
    #1;
    redir = ex | br | bp;
    tgt   = ex ? expc : (br ? brpc : bppc);
    e     = (mo.size() > 0) ? mo[0] : '{addr: 32'h0, stale: 1'b1};
    keep  = resp && !r && !redir && mo.size() > 0 && !e.stale;
`ifdef FETCH_BYPASS_EN
    byp = keep && mq.size() == 0;
`else
    byp = 1'b0;
`endif
    exp_rv = !r && !redir && (mq.size() + mo.size() < QD) && (mo.size() < MO);
    exp_ov = !r && (mq.size() > 0 || byp);
    last_ov = out_valid;
    chk("ic_req_valid", 32'(ic_req_valid), 32'(exp_rv));
    if (exp_rv) chk("ic_req_addr", ic_req_addr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_pc", out_pc, (mq.size() > 0) ? mq[0].pc : e.addr);
      chk("out_instr", out_instr, (mq.size() > 0) ? mq[0].instr : rdata);
    end
    if (ic_req_valid && ic_req_ready) begin
      lat = $urandom_range(lat_hi, lat_lo);
      icq.push_back('{ic_req_addr, $urandom, cyc + 1 + lat});
      n_acc++;
    end
    if (resp) icq.delete(0);
    if (r) begin
      m_pc = START;
      mq.delete();
      mo.delete();
    end else begin
      if (resp && mo.size() > 0) mo.delete(0);
      hs = exp_ov && ordy;
      if (hs && mq.size() > 0) mq.delete(0);
      else if (hs && byp) keep = 1'b0;
      if (keep) mq.push_back('{e.addr, rdata});
      if (redir) begin
        m_pc = tgt;
        mq.delete();
        foreach (mo[i]) mo[i].stale = 1'b1;
      end else if (exp_rv && rdy) begin
        mo.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    ic_resp_valid  = 1'b0;
    ctrl_excp_flag = 1'b0;
    ex_branch_flag = 1'b0;
    bp_branch_flag = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input bit rdy, input bit ordy);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, rdy, ordy);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    case ($urandom_range(3, 0))
      0:       t = 32'hFFFF_FFF8;
      1:       t = 32'hFFFF_FFFC;
      default: t = $urandom & 32'hFFFF_FFFC;
    endcase
    return t;
  endfunction

  initial begin
    bit found;
    n_cmp = 0; n_bad = 0; cyc = 0; n_acc = 0; lat_lo = 0; lat_hi = 0;
    m_pc = START;
    rst = 1'b1; ctrl_excp_flag = 1'b0; ex_branch_flag = 1'b0; bp_branch_flag = 1'b0;
    ctrl_excp_pc = 32'h0; ex_branch_pc = 32'h0; bp_branch_pc = 32'h0;
    ic_req_ready = 1'b0; ic_resp_valid = 1'b0; ic_resp_data = 32'h0; out_ready = 1'b0;
    @(negedge clk);

    do_reset();
    do_reset();
    chk("rst_req_valid", 32'(ic_req_valid), 32'd0);
    chk("rst_req_addr", ic_req_addr, START);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);

    // Streaming with a 1-cycle Icache.
    for (int i = 0; i < 12; i++) idle(1'b1, 1'b1);

    // Consumer stalled: only QDEPTH requests may go out.
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 12; i++) idle(1'b1, 1'b0);
    chk("stall_accepts", n_acc, QD);
    for (int i = 0; i < 6; i++) idle(1'b1, 1'b1);

    // Two requests in flight when a branch resolves.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0100, 1'b0, 32'h0, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      idle(1'b1, 1'b0);
      found = out_valid;
    end
    if (found) chk("redir_first_pc", out_pc, 32'h8000_0100);
    else       chk("redir_timeout", 32'd0, 32'd1);
    lat_lo = 0; lat_hi = 0;

    // Exception beats branch in the same cycle.
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'h8000_0100, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("excp_prio", ic_req_addr, 32'h0000_0200);
    for (int i = 0; i < 8; i++) idle(1'b1, 1'b1);

    // Address wrap.
    do_reset();
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(1'b1, 1'b1);
    chk("wrap_addr", ic_req_addr, 32'h0000_0000);
    for (int i = 0; i < 6; i++) idle(1'b1, 1'b1);

    // Response latency into an empty queue.
    do_reset();
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
`ifdef FETCH_BYPASS_EN
    chk("resp_same_cycle", 32'(last_ov), 32'd1);
`else
    chk("resp_same_cycle", 32'(last_ov), 32'd0);
`endif
    idle(1'b0, 1'b0);
    chk("resp_next_cycle", 32'(last_ov), 32'd1);

    // Random traffic.
    lat_lo = 0; lat_hi = 3;
    begin
      int ordy_pct;
      ordy_pct = 60;
      for (int i = 0; i < 4000; i++) begin
        if (i % 50 == 0) ordy_pct = $urandom_range(100, 0);
        step(($urandom % 200) == 0,
             ($urandom % 40) == 0, rand_tgt(),
             ($urandom % 25) == 0, rand_tgt(),
             ($urandom % 15) == 0, rand_tgt(),
             ($urandom % 10) < 7,
             $urandom_range(99, 0) < ordy_pct);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_queue.md
FETCH_PC_QUEUE -- requirements
Module: fetch_pc_queue

Interface
REQ-001 SHALL provide parameter: ADDR_WIDTH, 32, PC/address width in bits.
REQ-002 SHALL provide parameter: START_PC, 32'h8000_0000, PC loaded at reset.
REQ-003 SHALL provide parameter: QDEPTH, 4, fetch-queue entries, power of two, range 2..16.
REQ-004 SHALL provide parameter: MAX_OUTST, 2, maximum in-flight Icache requests, range 1..4.
REQ-005 SHALL have port: clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: ctrl_excp_flag in 1 / ctrl_excp_pc in ADDR_WIDTH  exception redirect.
REQ-008 SHALL have ports: ex_branch_flag in 1 / ex_branch_pc in ADDR_WIDTH  resolved-branch redirect.
REQ-009 SHALL have ports: bp_branch_flag in 1 / bp_branch_pc in ADDR_WIDTH  predicted-taken redirect.
REQ-010 SHALL have ports: ic_req_valid out 1, ic_req_ready in 1, ic_req_addr out ADDR_WIDTH  Icache request.
REQ-011 SHALL have ports: ic_resp_valid in 1, ic_resp_data in 32  Icache response, in request order, no backpressure.
REQ-012 SHALL have ports: out_valid out 1, out_ready in 1, out_pc out ADDR_WIDTH, out_instr out 32  to IFID.

Function
REQ-013 SHALL maintain next_pc; redirect priority: ctrl_excp_flag > ex_branch_flag > bp_branch_flag.
REQ-014 SHALL, in any cycle with a redirect: load next_pc with the winning target, flush the queue, force ic_req_valid low, and mark all currently outstanding requests stale.
REQ-015 SHALL assert ic_req_valid with ic_req_addr = next_pc when no redirect and (queue count + outstanding) < QDEPTH and outstanding < MAX_OUTST.
REQ-016 SHALL, on ic_req_valid && ic_req_ready, increment next_pc by 4, modulo 2^ADDR_WIDTH, and increment outstanding.
REQ-017 SHALL hold ic_req_addr stable while ic_req_valid && !ic_req_ready.
REQ-018 SHALL decrement outstanding on every ic_resp_valid; simultaneous request accept and response leave it unchanged.
REQ-019 SHALL discard responses while stale count > 0 (decrementing it); a response arriving in a redirect cycle is discarded.
REQ-020 SHALL push each non-discarded response as {pc, instr}, pc being the address of its request (tracked in a MAX_OUTST-deep address FIFO).
REQ-021 SHALL present the queue head on out_*; pop on out_valid && out_ready; push and pop in one cycle when full SHALL both succeed.
REQ-022 SHALL never overflow: reservation in REQ-015 guarantees space for every outstanding response.
REQ-023 SHALL keep out_pc/out_instr stable while out_valid && !out_ready.

Reset
REQ-024 SHALL on rst: next_pc = START_PC, ic_req_valid = 0, outstanding = 0, stale = 0, queue empty, out_valid = 0, out_pc = 0, out_instr = 0.
REQ-025 SHALL give rst priority over redirects; responses arriving in the reset cycle or for pre-reset requests are discarded (stale = outstanding at reset is NOT required; the Icache is reset together).
REQ-026 SHALL issue first request (addr START_PC) in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL support macro FETCH_BYPASS_EN: when defined, a non-discarded response arriving with the queue empty drives out_valid combinationally in the same cycle (0-cycle latency) and is not enqueued if popped that cycle.
REQ-028 SHALL, without FETCH_BYPASS_EN, register every response into the queue; out_valid rises the cycle after ic_resp_valid (1-cycle latency).

Verification
REQ-029 SHALL cover: release rst, ic_req_ready=1, 1-cycle Icache -> addrs 8000_0000, 8000_0004, 8000_0008 issued; out_pc sequence identical.
REQ-030 SHALL cover: out_ready=0 with QDEPTH=4 -> at most 4 requests issued, ic_req_valid then low until a pop.
REQ-031 SHALL cover: 2 outstanding requests, ex_branch_flag to 8000_0100 -> both responses dropped, next out_pc = 8000_0100.
REQ-032 SHALL cover: ctrl_excp_flag (pc 0000_0200) and ex_branch_flag (8000_0100) same cycle -> ic_req_addr = 0000_0200.
REQ-033 SHALL cover: next_pc = FFFF_FFFC accepted -> next ic_req_addr = 0000_0000.
REQ-034 SHALL cover: empty queue, response 0000_0013 at cycle N -> out_valid at N with FETCH_BYPASS_EN, N+1 without.
